// File: rtl/sy_ppl_mmu_dtlb_pkg.sv
// Shared types, constants and helpers for the data-side Sv39 TLB.
package sy_ppl_mmu_dtlb_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned VPN_WTH = 27;
  localparam int unsigned PPN_WTH = 44;

  // Sv39 leaf levels
  localparam logic [1:0] LVL_1G = 2'd2;
  localparam logic [1:0] LVL_2M = 2'd1;
  localparam logic [1:0] LVL_4K = 2'd0;

  // PTE flag bit positions
  localparam int unsigned PTE_V       = 0;
  localparam int unsigned PTE_R       = 1;
  localparam int unsigned PTE_W       = 2;
  localparam int unsigned PTE_X       = 3;
  localparam int unsigned PTE_U       = 4;
  localparam int unsigned PTE_G       = 5;
  localparam int unsigned PTE_A       = 6;
  localparam int unsigned PTE_D       = 7;
  localparam int unsigned PTE_PPN_LSB = 10;

  // Effective privilege encodings
  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;

  typedef enum logic [4:0] {
    INST_ADDR_MISALIGNED = 5'd0,
    INST_PAGE_FAULT      = 5'd12,
    LD_PAGE_FAULT        = 5'd13,
    ST_AMO_PAGE_FAULT    = 5'd15
  } excp_e;

  typedef struct packed {
    excp_e excp;
  } excp_cause_t;

  typedef struct packed {
    logic             valid;
    excp_cause_t      cause;
    logic [XLEN-1:0]  tval;
  } excp_t;

  typedef struct packed {
    logic u;
    logic r;
    logic w;
    logic x;
    logic a;
    logic d;
  } pte_perm_t;

  typedef struct packed {
    logic               valid;
    logic [VPN_WTH-1:0] vpn;
    logic [PPN_WTH-1:0] ppn;
    logic [1:0]         level;
    pte_perm_t          perm;
  } dtlb_entry_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PTW_REQ  = 3'd1,
    PTW_WAIT = 3'd2,
    RESP     = 3'd3,
    DRAIN    = 3'd4
  } dtlb_state_e;

  // Physical address for a leaf of the given level, zero-extended to 64 bits
  function automatic logic [XLEN-1:0] sv39_paddr(input logic [PPN_WTH-1:0] ppn,
                                                 input logic [1:0]         level,
                                                 input logic [29:0]        va_lo);
    logic [55:0] pa;
    case (level)
      LVL_1G:  pa = {ppn[43:18], va_lo[29:0]};
      LVL_2M:  pa = {ppn[43:9],  va_lo[20:0]};
      default: pa = {ppn,        va_lo[11:0]};
    endcase
    return {8'b0, pa};
  endfunction

  // Bits 63:38 of a VA; canonical when 63:39 all replicate bit 38
  function automatic logic sv39_canonical(input logic [25:0] va_hi);
    return va_hi[25:1] == {25{va_hi[0]}};
  endfunction

  function automatic excp_t page_fault(input logic [XLEN-1:0] va, input logic is_store);
    excp_t e;
    e            = '0;
    e.valid      = 1'b1;
    e.cause.excp = is_store ? ST_AMO_PAGE_FAULT : LD_PAGE_FAULT;
    e.tval       = va;
    return e;
  endfunction

endpackage

// File: rtl/sy_ppl_mmu_perm_chk.sv
// Combinational leaf-PTE permission check for data accesses.
module sy_ppl_mmu_perm_chk
  import sy_ppl_mmu_dtlb_pkg::*;
(
  input  pte_perm_t  perm,
  input  logic       is_store,
  input  logic [1:0] priv_lvl,
  input  logic       sum,
  input  logic       mxr,
  output logic       fault_c
);

  // Any single violated rule raises the fault
  always_comb begin
    fault_c = 1'b0;
    if (!perm.a)                                      fault_c = 1'b1;
    if (!is_store && !(perm.r || (perm.x && mxr)))    fault_c = 1'b1;
    if (is_store && (!perm.w || !perm.d))             fault_c = 1'b1;
    if ((priv_lvl == PRIV_U) && !perm.u)              fault_c = 1'b1;
    if ((priv_lvl == PRIV_S) && perm.u && !sum)       fault_c = 1'b1;
  end

endmodule

// File: rtl/sy_ppl_mmu_dtlb.sv
// Fully-associative Sv39 data TLB: combinational hit, registered response,
// page-table-walker refill on miss.
module sy_ppl_mmu_dtlb
  import sy_ppl_mmu_dtlb_pkg::*;
#(
  parameter int unsigned DTLB_ENTRIES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        sfence_vma_i,
  input  logic        en_translation_i,
  input  logic [1:0]  priv_lvl_i,
  input  logic        sum_i,
  input  logic        mxr_i,
  input  logic        lsu_mmu__req_i,
  input  logic [63:0] lsu_mmu__vaddr_i,
  input  logic        lsu_mmu__is_store_i,
  output logic        mmu_lsu__hit_o,
  output logic        mmu_lsu__valid_o,
  output logic [63:0] mmu_lsu__paddr_o,
  output excp_t       mmu_lsu__ex_o,
  output logic        dtlb_ptw__req_o,
  output logic [63:0] dtlb_ptw__vaddr_o,
  input  logic        ptw_dtlb__rdy_i,
  input  logic        ptw_dtlb__vld_i,
  input  logic [63:0] ptw_dtlb__pte_i,
  input  logic [1:0]  ptw_dtlb__level_i,
  input  logic        ptw_dtlb__ex_i
);

  localparam int unsigned DTLB_IDX_WTH = $clog2(DTLB_ENTRIES);

  dtlb_state_e             state, state_nxt;
  dtlb_entry_t             entries [DTLB_ENTRIES];
  logic [DTLB_IDX_WTH-1:0] victim_ptr, hit_idx, free_idx, refill_idx;
  logic                    hit_any, free_any;
  logic [63:0]             lat_vaddr;
  logic                    lat_store;
  logic                    walk_ex;
  logic [PPN_WTH-1:0]      walk_ppn;
  logic [1:0]              walk_level;
  pte_perm_t               walk_perm, pte_perm, chk_perm;
  logic                    chk_store, perm_fault;
  logic [VPN_WTH-1:0]      req_vpn;
  logic                    req_ok, bypass, canon, miss, refill_en, resp_en;
  logic                    unused_pte;

  assign req_vpn   = lsu_mmu__vaddr_i[38:12];
  assign req_ok    = lsu_mmu__req_i && (state == IDLE) && !flush_i;
  assign bypass    = !en_translation_i;
  assign canon     = sv39_canonical(lsu_mmu__vaddr_i[63:38]);
  assign miss      = req_ok && !bypass && canon && !hit_any;
  assign refill_en = (state == PTW_WAIT) && ptw_dtlb__vld_i && !flush_i &&
                     !ptw_dtlb__ex_i && !sfence_vma_i;
  assign resp_en   = (state == RESP) && !flush_i;
  assign refill_idx = free_any ? free_idx : victim_ptr;

  assign mmu_lsu__hit_o    = req_ok && (bypass || !canon || hit_any);
  assign dtlb_ptw__req_o   = (state == PTW_REQ);
  assign dtlb_ptw__vaddr_o = lat_vaddr;

  assign pte_perm = '{u: ptw_dtlb__pte_i[PTE_U], r: ptw_dtlb__pte_i[PTE_R],
                      w: ptw_dtlb__pte_i[PTE_W], x: ptw_dtlb__pte_i[PTE_X],
                      a: ptw_dtlb__pte_i[PTE_A], d: ptw_dtlb__pte_i[PTE_D]};
  assign unused_pte = ^{ptw_dtlb__pte_i[63:54], ptw_dtlb__pte_i[9:8],
                        ptw_dtlb__pte_i[PTE_G], ptw_dtlb__pte_i[PTE_V]};

  // Tag match across all entries; lowest matching index wins
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = int'(DTLB_ENTRIES) - 1; i >= 0; i--) begin
      if (entries[i].valid &&
          (entries[i].vpn[26:18] == req_vpn[26:18]) &&
          ((entries[i].level >= LVL_1G) || (entries[i].vpn[17:9] == req_vpn[17:9])) &&
          ((entries[i].level != LVL_4K) || (entries[i].vpn[8:0] == req_vpn[8:0]))) begin
        hit_any = 1'b1;
        hit_idx = DTLB_IDX_WTH'(i);
      end
    end
  end

  // Lowest-index invalid entry for refill
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = int'(DTLB_ENTRIES) - 1; i >= 0; i--) begin
      if (!entries[i].valid) begin
        free_any = 1'b1;
        free_idx = DTLB_IDX_WTH'(i);
      end
    end
  end

  // One checker serves the hit path in IDLE and the walked PTE in RESP
  always_comb begin
    chk_perm  = entries[hit_idx].perm;
    chk_store = lsu_mmu__is_store_i;
    if (state == RESP) begin
      chk_perm  = walk_perm;
      chk_store = lat_store;
    end
  end

  sy_ppl_mmu_perm_chk u_perm_chk (
    .perm     (chk_perm),
    .is_store (chk_store),
    .priv_lvl (priv_lvl_i),
    .sum      (sum_i),
    .mxr      (mxr_i),
    .fault_c  (perm_fault)
  );

  // Next-state logic for the miss/walk sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (miss) state_nxt = PTW_REQ;
      PTW_REQ: begin
        if (flush_i)              state_nxt = ptw_dtlb__rdy_i ? DRAIN : IDLE;
        else if (ptw_dtlb__rdy_i) state_nxt = PTW_WAIT;
      end
      PTW_WAIT: begin
        if (ptw_dtlb__vld_i)      state_nxt = flush_i ? IDLE : RESP;
        else if (flush_i)         state_nxt = DRAIN;
      end
      RESP:     state_nxt = IDLE;
      DRAIN:    if (ptw_dtlb__vld_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register, latched request and captured walk result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      lat_vaddr  <= '0;
      lat_store  <= 1'b0;
      walk_ex    <= 1'b0;
      walk_ppn   <= '0;
      walk_level <= '0;
      walk_perm  <= '0;
    end else begin
      state <= state_nxt;
      if (miss) begin
        lat_vaddr <= lsu_mmu__vaddr_i;
        lat_store <= lsu_mmu__is_store_i;
      end
      if ((state == PTW_WAIT) && ptw_dtlb__vld_i) begin
        walk_ex    <= ptw_dtlb__ex_i;
        walk_ppn   <= ptw_dtlb__pte_i[PTE_PPN_LSB +: PPN_WTH];
        walk_level <= ptw_dtlb__level_i;
        walk_perm  <= pte_perm;
      end
    end
  end

  // Entry array and round-robin victim pointer; sfence overrides refill
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      victim_ptr <= '0;
      for (int i = 0; i < int'(DTLB_ENTRIES); i++) entries[i] <= '0;
    end else if (sfence_vma_i) begin
      for (int i = 0; i < int'(DTLB_ENTRIES); i++) entries[i].valid <= 1'b0;
    end else if (refill_en) begin
      entries[refill_idx] <= '{valid: 1'b1,
                               vpn:   lat_vaddr[38:12],
                               ppn:   ptw_dtlb__pte_i[PTE_PPN_LSB +: PPN_WTH],
                               level: ptw_dtlb__level_i,
                               perm:  pte_perm};
      if (!free_any) victim_ptr <= victim_ptr + DTLB_IDX_WTH'(1);
    end
  end

  // Registered response; all fields return to zero when not valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mmu_lsu__valid_o <= 1'b0;
      mmu_lsu__paddr_o <= '0;
      mmu_lsu__ex_o    <= '0;
    end else begin
      mmu_lsu__valid_o <= 1'b0;
      mmu_lsu__paddr_o <= '0;
      mmu_lsu__ex_o    <= '0;
      if (mmu_lsu__hit_o) begin
        mmu_lsu__valid_o <= 1'b1;
        if (bypass) begin
          mmu_lsu__paddr_o <= lsu_mmu__vaddr_i;
        end else if (!canon || perm_fault) begin
          mmu_lsu__ex_o <= page_fault(lsu_mmu__vaddr_i, lsu_mmu__is_store_i);
        end else begin
          mmu_lsu__paddr_o <= sv39_paddr(entries[hit_idx].ppn, entries[hit_idx].level,
                                         lsu_mmu__vaddr_i[29:0]);
        end
      end else if (resp_en) begin
        mmu_lsu__valid_o <= 1'b1;
        if (walk_ex || perm_fault) begin
          mmu_lsu__ex_o <= page_fault(lat_vaddr, lat_store);
        end else begin
          mmu_lsu__paddr_o <= sv39_paddr(walk_ppn, walk_level, lat_vaddr[29:0]);
        end
      end
    end
  end

endmodule
